// File: rtl/cuda_thread_dispatcher.sv
// Issue-side dispatcher: buffers instructions, drives one at a time into a cuda_thread,
// and returns a tagged completion record (or a watchdog error record) to writeback.
module cuda_thread_dispatcher #(
  parameter int W           = 32,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_opcode,
  input  logic                     in_is_fp,
  input  logic [W-1:0]             in_op1,
  input  logic [W-1:0]             in_op2,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     thr_valid,
  output logic [5:0]               thr_opcode,
  output logic                     thr_is_fp,
  output logic [W-1:0]             thr_op1,
  output logic [W-1:0]             thr_op2,
  input  logic                     thr_ready,
  input  logic [W-1:0]             thr_result,
  input  logic                     thr_done,
  output logic                     wb_valid,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [W-1:0]             wb_result,
  output logic                     wb_err,
  input  logic                     wb_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic [WD_W-1:0]    wd_cnt;
  logic [TAG_W-1:0]   inflight_tag;
  logic               push, pop, wd_fire;

  logic [5:0]         mem_opcode [DEPTH];
  logic               mem_is_fp  [DEPTH];
  logic [W-1:0]       mem_op1    [DEPTH];
  logic [W-1:0]       mem_op2    [DEPTH];
  logic [TAG_W-1:0]   mem_tag    [DEPTH];

  assign push       = in_valid && in_ready;
  assign pop        = thr_valid && thr_ready;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign fifo_count = count;
  // Fires on the last permitted WAIT cycle so the record appears after exactly TIMEOUT_CYC cycles.
  assign wd_fire    = (TIMEOUT_CYC != 0) && (state == WAIT) && !thr_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_opcode[wr_ptr] <= in_opcode;
      mem_is_fp[wr_ptr]  <= in_is_fp;
      mem_op1[wr_ptr]    <= in_op1;
      mem_op2[wr_ptr]    <= in_op2;
      mem_tag[wr_ptr]    <= in_tag;
    end
    if (pop) inflight_tag <= mem_tag[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (count != '0) state_next = ISSUE;
      ISSUE: if (thr_ready) state_next = WAIT;
      WAIT:  if (thr_done || wd_fire) state_next = HOLD;
      HOLD:  if (wb_ready) state_next = (count_next != '0) ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    thr_valid  = (state == ISSUE);
    thr_opcode = '0;
    thr_is_fp  = 1'b0;
    thr_op1    = '0;
    thr_op2    = '0;
    if (thr_valid) begin
      thr_opcode = mem_opcode[rd_ptr];
      thr_is_fp  = mem_is_fp[rd_ptr];
      thr_op1    = mem_op1[rd_ptr];
      thr_op2    = mem_op2[rd_ptr];
    end
    in_ready = (count < CNT_W'(DEPTH));
    busy     = (state != IDLE) || (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      wb_valid    <= 1'b0;
      wb_err      <= 1'b0;
      wb_tag      <= '0;
      wb_result   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (pop) wd_cnt <= '0;
      else if (state == WAIT && !thr_done) wd_cnt <= wd_cnt + 1'b1;

      if (state == WAIT && thr_done) begin
        wb_valid  <= 1'b1;
        wb_err    <= 1'b0;
        wb_tag    <= inflight_tag;
        wb_result <= thr_result;
      end else if (wd_fire) begin
        wb_valid    <= 1'b1;
        wb_err      <= 1'b1;
        wb_tag      <= inflight_tag;
        wb_result   <= '0;
        timeout_err <= 1'b1;
      end else if (state == HOLD && wb_ready) begin
        wb_valid <= 1'b0;
        wb_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cuda_thread_dispatcher.sv
// Directed bench for cuda_thread_dispatcher: table of single-instruction transactions
// followed by hand-written sequences for backpressure, watchdog, reset and ordering.
module tb_cuda_thread_dispatcher;

  localparam int W = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int TIMEOUT_CYC = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [5:0]       in_opcode;
  logic             in_is_fp;
  logic [W-1:0]     in_op1, in_op2;
  logic [TAG_W-1:0] in_tag;
  logic             thr_valid;
  logic [5:0]       thr_opcode;
  logic             thr_is_fp;
  logic [W-1:0]     thr_op1, thr_op2;
  logic             thr_ready;
  logic [W-1:0]     thr_result;
  logic             thr_done;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [W-1:0]     wb_result;
  logic             wb_err;
  logic             wb_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic             busy, timeout_err;

  cuda_thread_dispatcher #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_is_fp(in_is_fp),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .thr_valid(thr_valid), .thr_opcode(thr_opcode), .thr_is_fp(thr_is_fp),
    .thr_op1(thr_op1), .thr_op2(thr_op2), .thr_ready(thr_ready),
    .thr_result(thr_result), .thr_done(thr_done),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_result(wb_result), .wb_err(wb_err),
    .wb_ready(wb_ready), .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [5:0]       op;
    logic             fp;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     res;
    int               tstall;
    int               ddelay;
    int               wstall;
  } vec_t;

  int total = 0;
  int bad = 0;
  vec_t tbl [6];
  vec_t q4 [4];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input vec_t v);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_tag = v.tag; in_opcode = v.op; in_is_fp = v.fp;
    in_op1 = v.a; in_op2 = v.b;
    tick();
    in_valid = 1'b0;
  endtask

  // Thread + writeback model: accept after tstall, done after ddelay WAIT cycles, hold wstall.
  task automatic serve(input vec_t v, input int hold_cnt);
    thr_ready = 1'b0;
    for (int i = 0; i < 50 && !thr_valid; i++) tick();
    chk("thr_valid", {31'd0, thr_valid}, 32'd1);
    chk("thr_opcode", {26'd0, thr_opcode}, {26'd0, v.op});
    chk("thr_is_fp", {31'd0, thr_is_fp}, {31'd0, v.fp});
    chk("thr_op1", thr_op1, v.a);
    chk("thr_op2", thr_op2, v.b);
    for (int i = 0; i < v.tstall; i++) begin
      tick();
      chk("thr_hold_valid", {31'd0, thr_valid}, 32'd1);
      chk("thr_hold_op1", thr_op1, v.a);
    end
    thr_ready = 1'b1;
    tick();
    thr_ready = 1'b0;
    for (int i = 0; i < v.ddelay; i++) begin
      chk("wb_early", {31'd0, wb_valid}, 32'd0);
      tick();
    end
    thr_done = 1'b1; thr_result = v.res;
    tick();
    thr_done = 1'b0; thr_result = '0;
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wb_tag", {28'd0, wb_tag}, {28'd0, v.tag});
    chk("wb_result", wb_result, v.res);
    chk("wb_err", {31'd0, wb_err}, 32'd0);
    for (int i = 0; i < v.wstall; i++) begin
      tick();
      chk("hold_valid", {31'd0, wb_valid}, 32'd1);
      chk("hold_tag", {28'd0, wb_tag}, {28'd0, v.tag});
      chk("hold_result", wb_result, v.res);
      chk("hold_thr_valid", {31'd0, thr_valid}, 32'd0);
      chk("hold_count", {29'd0, fifo_count}, hold_cnt);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("wb_drop", {31'd0, wb_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_opcode = '0; in_is_fp = 1'b0; in_op1 = '0; in_op2 = '0;
    in_tag = '0; thr_ready = 1'b0; thr_result = '0; thr_done = 1'b0; wb_ready = 1'b0;

    tbl[0] = '{4'd3, 6'h01, 1'b0, 32'd3,        32'd4,        32'h7,        0, 1, 0};
    tbl[1] = '{4'd5, 6'h02, 1'b0, 32'd100,      32'd58,       32'd42,       2, 1, 1};
    tbl[2] = '{4'd7, 6'h10, 1'b1, 32'h3f800000, 32'h40000000, 32'h40400000, 0, 3, 2};
    tbl[3] = '{4'd15, 6'h3f, 1'b0, 32'hffffffff, 32'h1,       32'h0,        1, 2, 0};
    tbl[4] = '{4'd0, 6'h05, 1'b0, 32'h0000f0f0, 32'h00000f0f, 32'h0000ffff, 3, 1, 3};
    tbl[5] = '{4'd9, 6'h11, 1'b1, 32'h12345678, 32'h9abcdef0, 32'hdeadbeef, 0, 5, 1};

    do_reset();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_thr_valid", {31'd0, thr_valid}, 32'd0);
    chk("rst_thr_op1", thr_op1, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      push(tbl[i]);
      serve(tbl[i], 0);
      tick();
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Backpressure: thread stalled, FIFO fills, fifth push refused, drain in order
    for (int i = 0; i < 4; i++) q4[i] = '{TAG_W'(i + 8), 6'(i + 2), 1'b0, 32'(i * 10), 32'(i), 32'(i * 11 + 1), 0, 1, 0};
    q4[0].wstall = 10;
    thr_ready = 1'b0;
    push(q4[0]);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, thr_valid}, 32'd1);
      chk("stall_opcode", {26'd0, thr_opcode}, {26'd0, q4[0].op});
      chk("stall_op2", thr_op2, q4[0].b);
    end
    for (int i = 1; i < 4; i++) push(q4[i]);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_tag = 4'd1; in_op1 = 32'h55;
    tick();
    in_valid = 1'b0;
    chk("refused_count", {29'd0, fifo_count}, 32'd4);
    for (int i = 0; i < 4; i++) serve(q4[i], 3 - i);
    tick();
    chk("drain_busy", {31'd0, busy}, 32'd0);

    // Watchdog: no done for TIMEOUT_CYC cycles
    push(tbl[1]);
    for (int i = 0; i < 50 && !thr_valid; i++) tick();
    thr_ready = 1'b1;
    tick();
    thr_ready = 1'b0;
    for (int i = 1; i < TIMEOUT_CYC; i++) begin
      tick();
      if (wb_valid) chk("wd_early", {31'd0, wb_valid}, 32'd0);
    end
    tick();
    chk("wd_valid", {31'd0, wb_valid}, 32'd1);
    chk("wd_err", {31'd0, wb_err}, 32'd1);
    chk("wd_result", wb_result, 32'd0);
    chk("wd_tag", {28'd0, wb_tag}, {28'd0, tbl[1].tag});
    chk("wd_flag", {31'd0, timeout_err}, 32'd1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("wd_clear_valid", {31'd0, wb_valid}, 32'd0);
    chk("wd_clear_err", {31'd0, wb_err}, 32'd0);
    thr_done = 1'b1; thr_result = 32'h77;
    tick();
    thr_done = 1'b0;
    tick();
    chk("late_done", {31'd0, wb_valid}, 32'd0);
    push(tbl[2]);
    serve(tbl[2], 0);
    chk("wd_sticky", {31'd0, timeout_err}, 32'd1);
    do_reset();
    chk("wd_rst", {31'd0, timeout_err}, 32'd0);

    // Reset in WAIT with two queued
    thr_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(q4[i]);
    for (int i = 0; i < 50 && !thr_valid; i++) tick();
    thr_ready = 1'b1;
    tick();
    thr_ready = 1'b0;
    chk("pre_rst_count", {29'd0, fifo_count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_thr", {31'd0, thr_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    thr_done = 1'b1; thr_result = 32'h99;
    tick();
    thr_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_wb", {31'd0, wb_valid}, 32'd0);
    end
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Ordering with stalls and a spurious done in IDLE
    thr_done = 1'b1; thr_result = 32'h1234;
    tick();
    thr_done = 1'b0;
    tick();
    chk("spurious_wb", {31'd0, wb_valid}, 32'd0);
    chk("spurious_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++)
      q4[i] = '{TAG_W'(i), 6'(i + 20), i[0], 32'(i + 1), 32'(i * 3), 32'h100 + 32'(i),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3))};
    for (int i = 0; i < 4; i++) push(q4[i]);
    for (int i = 0; i < 4; i++) serve(q4[i], 3 - i);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_extra_wb", {31'd0, wb_valid}, 32'd0);
    end
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
